// File: rtl/binary_search_datapath.sv
// Datapath for a binary search over an external 32x8 synchronous RAM.
// The controller sequences strobes; this block holds key, bounds, and hit state.
module binary_search_datapath (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] A_in,
  input  logic       Load_A,
  input  logic       Init_Bound,
  input  logic       Update_L,
  input  logic       Update_R,
  input  logic       Found_True,
  input  logic       Done,
  input  logic [7:0] Mem_Q,
  output logic [4:0] Mem_Addr,
  output logic [7:0] A,
  output logic [7:0] Ram_Data,
  output logic [4:0] L_Bound,
  output logic [4:0] R_Bound,
  output logic       Found,
  output logic [4:0] Loc,
  output logic       Result_Valid,
  output logic       Proto_Err
);

  logic [5:0] sum;
  logic [4:0] mid;
  logic [5:0] mid_inc;
  logic [4:0] l_next, r_next;
  logic       bad_combo, move_l, move_r;

  // 6-bit sum so 31+31 cannot overflow before the halving
  assign sum      = {1'b0, L_Bound} + {1'b0, R_Bound};
  assign mid      = 5'(sum >> 1);
  assign Mem_Addr = mid;
  assign Ram_Data = Mem_Q;

  // Clamped moves keep L <= R and never wrap past 0 or 31
  assign mid_inc = {1'b0, mid} + 6'd1;
  assign l_next  = (mid_inc > {1'b0, R_Bound}) ? R_Bound : mid_inc[4:0];
  assign r_next  = ((mid == 5'd0) || ((mid - 5'd1) < L_Bound)) ? L_Bound : (mid - 5'd1);

  assign bad_combo = (Update_L & Update_R) | (Found_True & (Update_L | Update_R));
  assign move_l    = Update_L & ~Update_R & ~Found_True;
  assign move_r    = Update_R & ~Update_L & ~Found_True;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      A            <= '0;
      L_Bound      <= '0;
      R_Bound      <= 5'd31;
      Found        <= 1'b0;
      Loc          <= '0;
      Result_Valid <= 1'b0;
      Proto_Err    <= 1'b0;
    end else begin
      if (Load_A) A <= A_in;
      if (bad_combo) Proto_Err <= 1'b1;
      if (Init_Bound) begin
        L_Bound      <= '0;
        R_Bound      <= 5'd31;
        Found        <= 1'b0;
        Loc          <= '0;
        Result_Valid <= 1'b0;
      end else begin
        Result_Valid <= Done;
        if (Found_True) begin
          Found <= 1'b1;
          Loc   <= mid;
        end
        if (move_l) L_Bound <= l_next;
        if (move_r) R_Bound <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_binary_search_datapath.sv
// Bench: behavioural controller + RAM (mem[i]=2*i) driving the search datapath.
module tb_binary_search_datapath;
  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [7:0] A_in = '0;
  logic       Load_A = 0, Init_Bound = 0, Update_L = 0, Update_R = 0, Found_True = 0, Done = 0;
  logic [7:0] Mem_Q = '0;
  logic [4:0] Mem_Addr, L_Bound, R_Bound, Loc;
  logic [7:0] A, Ram_Data;
  logic       Found, Result_Valid, Proto_Err;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] mem [32];

  binary_search_datapath dut (
    .Clock(Clock), .Resetn(Resetn), .A_in(A_in), .Load_A(Load_A), .Init_Bound(Init_Bound),
    .Update_L(Update_L), .Update_R(Update_R), .Found_True(Found_True), .Done(Done),
    .Mem_Q(Mem_Q), .Mem_Addr(Mem_Addr), .A(A), .Ram_Data(Ram_Data), .L_Bound(L_Bound),
    .R_Bound(R_Bound), .Found(Found), .Loc(Loc), .Result_Valid(Result_Valid), .Proto_Err(Proto_Err)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) Mem_Q <= mem[Mem_Addr];

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Load_A = 0; Init_Bound = 0; Update_L = 0; Update_R = 0; Found_True = 0; Done = 0;
  endtask

  // Abstract controller: plain binary search with clamped bounds.
  // max_steps < 0 runs to completion; otherwise stop after that many bound updates.
  task automatic search(input int key, input int max_steps, output int ml, output int mr,
                        output int hit, output int loc);
    int mid, steps;
    A_in = 8'(key); Load_A = 1; Init_Bound = 1; tick(); clr();
    ml = 0; mr = 31; hit = 0; loc = 0; steps = 0;
    chk("init_L", 32'(L_Bound), 0); chk("init_R", 32'(R_Bound), 31);
    chk("init_A", 32'(A), 32'(key & 255));
    for (int it = 0; it < 12; it++) begin
      if (max_steps >= 0 && steps >= max_steps) return;
      tick();                          // wait state for RAM
      mid = (ml + mr) / 2;
      chk("mem_addr", 32'(Mem_Addr), 32'(mid));
      chk("ram_data", 32'(Ram_Data), 32'(2 * mid));
      chk("no_stale_found", 32'(Found), 0);
      chk("no_stale_loc", 32'(Loc), 0);
      if (2 * mid == key) begin
        Found_True = 1; tick(); clr();
        hit = 1; loc = mid;
        break;
      end else if (ml == mr) begin
        break;
      end else if (2 * mid < key) begin
        Update_L = 1; ml = (mid + 1 < mr) ? mid + 1 : mr;
      end else begin
        Update_R = 1; mr = (mid - 1 > ml) ? mid - 1 : ml;
      end
      tick(); clr(); steps++;
      chk("step_L", 32'(L_Bound), 32'(ml)); chk("step_R", 32'(R_Bound), 32'(mr));
    end
    Done = 1; tick();
    chk("rv_done", 32'(Result_Valid), 1);
    chk("found", 32'(Found), 32'(hit)); if (hit != 0) chk("loc", 32'(Loc), 32'(loc));
    tick();
    chk("rv_hold", 32'(Result_Valid), 1);
    Done = 0; tick();
    chk("rv_clear", 32'(Result_Valid), 0);
  endtask

  initial begin
    int ml, mr, hit, loc, key, rl, rr, rf, rloc, rpe, mid;
    logic ul, ur, ft;
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);

    // reset state
    Load_A = 1; A_in = 8'd99; Init_Bound = 0; Update_L = 1; Found_True = 1;
    tick(); tick();
    chk("rst_A", 32'(A), 0); chk("rst_L", 32'(L_Bound), 0); chk("rst_R", 32'(R_Bound), 31);
    chk("rst_found", 32'(Found), 0); chk("rst_loc", 32'(Loc), 0);
    chk("rst_rv", 32'(Result_Valid), 0); chk("rst_pe", 32'(Proto_Err), 0);
    chk("rst_mid", 32'(Mem_Addr), 15);
    clr(); Resetn = 1; tick();

    // idle hold
    tick(); tick();
    chk("hold_L", 32'(L_Bound), 0); chk("hold_R", 32'(R_Bound), 31); chk("hold_A", 32'(A), 0);

    // key 20: mid 15,7,11,9,10 -> hit at 10
    search(20, -1, ml, mr, hit, loc);
    chk("k20_hit", 32'(hit), 1); chk("k20_loc", 32'(loc), 10);
    chk("k20_L", 32'(ml), 10); chk("k20_R", 32'(mr), 10);

    // key 63: L climbs to 31, miss
    search(63, -1, ml, mr, hit, loc);
    chk("k63_L", 32'(L_Bound), 31); chk("k63_mid", 32'(Mem_Addr), 31);
    chk("k63_ram", 32'(Ram_Data), 62); chk("k63_found", 32'(Found), 0);

    // key 0: R shrinks to 0, then an extra Update_R must not wrap
    search(0, -1, ml, mr, hit, loc);
    chk("k0_R", 32'(R_Bound), 0); chk("k0_loc", 32'(Loc), 0); chk("k0_found", 32'(Found), 1);
    Update_R = 1; tick(); clr();
    chk("k0_nowrap_R", 32'(R_Bound), 0); chk("k0_nowrap_L", 32'(L_Bound), 0);
    chk("k0_found_kept", 32'(Found), 1);

    // illegal combo: both updates at L=0,R=31
    Init_Bound = 1; tick(); clr();
    chk("pe_pre", 32'(Proto_Err), 0);
    Update_L = 1; Update_R = 1; tick(); clr();
    chk("pe_L", 32'(L_Bound), 0); chk("pe_R", 32'(R_Bound), 31); chk("pe_set", 32'(Proto_Err), 1);
    Init_Bound = 1; tick(); clr();
    chk("pe_sticky", 32'(Proto_Err), 1);
    Resetn = 0; tick(); Resetn = 1;
    chk("pe_rst", 32'(Proto_Err), 0);

    // reset mid-search at L=8,R=14
    search(20, 2, ml, mr, hit, loc);
    chk("mid_L", 32'(L_Bound), 8); chk("mid_R", 32'(R_Bound), 14);
    Resetn = 0; tick(); Resetn = 1;
    chk("abort_A", 32'(A), 0); chk("abort_L", 32'(L_Bound), 0); chk("abort_R", 32'(R_Bound), 31);
    chk("abort_addr", 32'(Mem_Addr), 15); chk("abort_found", 32'(Found), 0);
    chk("abort_rv", 32'(Result_Valid), 0); chk("abort_pe", 32'(Proto_Err), 0);

    // back-to-back 20 then 50; search() checks Loc stays 0 until the hit
    search(20, -1, ml, mr, hit, loc);
    search(50, -1, ml, mr, hit, loc);
    chk("b2b_loc", 32'(Loc), 25); chk("b2b_found", 32'(Found), 1);

    // random keys: even keys in range hit at key/2, odd keys miss
    for (int n = 0; n < 8; n++) begin
      key = int'($urandom_range(0, 63));
      search(key, -1, ml, mr, hit, loc);
      chk("rnd_found", 32'(Found), 32'((key % 2) == 0));
      if (key % 2 == 0) chk("rnd_loc", 32'(Loc), 32'(key / 2));
    end

    // random strobe soup against an abstract model (reset clears Proto_Err first)
    Resetn = 0; tick(); Resetn = 1;
    rl = 0; rr = 31; rf = 0; rloc = 0; rpe = 0;
    for (int n = 0; n < 60; n++) begin
      ul = 1'($urandom_range(0, 1)); ur = 1'($urandom_range(0, 1));
      ft = ($urandom_range(0, 7) == 0);
      Update_L = ul; Update_R = ur; Found_True = ft; tick(); clr();
      mid = (rl + rr) / 2;
      if ((ul && ur) || (ft && (ul || ur))) rpe = 1;
      if (ft) begin rf = 1; rloc = mid; end
      else if (ul && !ur) rl = (mid + 1 < rr) ? mid + 1 : rr;
      else if (ur && !ul) rr = (mid - 1 > rl) ? mid - 1 : rl;
      chk("soup_L", 32'(L_Bound), 32'(rl)); chk("soup_R", 32'(R_Bound), 32'(rr));
      chk("soup_found", 32'(Found), 32'(rf)); chk("soup_loc", 32'(Loc), 32'(rloc));
      chk("soup_pe", 32'(Proto_Err), 32'(rpe));
      chk("soup_order", 32'(L_Bound <= R_Bound), 1);
      if (rl == rr && $urandom_range(0, 3) == 0) begin
        Init_Bound = 1; tick(); clr(); rl = 0; rr = 31; rf = 0; rloc = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/binary_search_datapath.md
BINARY_SEARCH_DATAPATH -- requirements
Module: binary_search_datapath

Interface
REQ-001: Clock  input  1  single system clock; all state updates on posedge Clock.
REQ-002: Resetn  input  1  synchronous, active-low reset; sampled on posedge Clock.
REQ-003: A_in  input  8  search key from switches; captured only on Load_A.
REQ-004: Load_A, Init_Bound, Update_L, Update_R, Found_True, Done  input  1 each  control strobes from the search controller.
REQ-005: Mem_Addr  output  5  read address to external 32x8 synchronous RAM; equals combinational midpoint Mid.
REQ-006: Mem_Q  input  8  RAM read data; valid one cycle after Mem_Addr.
REQ-007: A  output  8  registered search key, returned to controller.
REQ-008: Ram_Data  output  8  direct pass-through of Mem_Q to controller.
REQ-009: L_Bound, R_Bound  output  5 each  registered left/right search bounds.
REQ-010: Found  output  1  registered hit flag.
REQ-011: Loc  output  5  registered index of hit; meaningful only when Found=1.
REQ-012: Result_Valid  output  1  registered; 1 while Done=1 and the current search has completed.
REQ-013: Proto_Err  output  1  sticky flag for illegal control combinations.

Function
REQ-014: Mid SHALL equal (L_Bound + R_Bound) >> 1, with the sum formed at 6 bits (no overflow; 31+31 gives Mid=31).
REQ-015: Load_A=1 SHALL set A <= A_in; otherwise A holds.
REQ-016: Init_Bound=1 SHALL set L_Bound<=0, R_Bound<=31, Found<=0, Loc<=0, Result_Valid<=0; Init_Bound has priority over Update_L, Update_R and Found_True.
REQ-017: Update_L=1 SHALL set L_Bound <= min(Mid+1, R_Bound); Mid=31 SHALL leave L_Bound=31 (no wrap to 0).
REQ-018: Update_R=1 SHALL set R_Bound <= max(Mid-1, L_Bound); Mid=0 SHALL leave R_Bound=0 (no wrap to 31).
REQ-019: Both clamps SHALL guarantee L_Bound <= R_Bound at all times after reset.
REQ-020: Found_True=1 SHALL set Found<=1 and Loc<=Mid in the same edge; a later Update_L or Update_R SHALL NOT clear Found.
REQ-021: Update_L and Update_R asserted together SHALL update neither bound and SHALL set Proto_Err<=1.
REQ-022: Found_True together with Update_L or Update_R SHALL set Proto_Err<=1; Found/Loc SHALL still be captured; bounds SHALL hold.
REQ-023: Result_Valid SHALL go 1 on the first edge where Done=1, stay 1 while Done=1, and clear on the edge after Done falls or on Init_Bound.
REQ-024: Proto_Err SHALL clear only on reset.
REQ-025: Latency: bound updates SHALL be visible on L_Bound/R_Bound and Mem_Addr one cycle after the strobe. Ram_Data for the new Mid SHALL be valid one further cycle later, matching the controller's one-cycle wait state.
REQ-026: With no strobe asserted, all registers SHALL hold.

Reset
REQ-027: Resetn=0 at a posedge SHALL set A=0, L_Bound=0, R_Bound=31, Found=0, Loc=0, Result_Valid=0, Proto_Err=0, overriding all strobes.
REQ-028: Reset asserted mid-search SHALL abandon the search; the next search SHALL start from the REQ-027 values with no residue.

Verification (bench RAM: mem[i]=2*i; controller modelled or instantiated)
REQ-029: A_in=20 search -> Mid sequence 15,7,11,9,10; bounds (0,14),(8,14),(8,10),(10,10); Found=1, Loc=10, Result_Valid=1 during Done.
REQ-030: A_in=63 search -> L_Bound climbs to 31, Mid=31; Ram_Data=62; Found=0, Result_Valid=1.
REQ-031: A_in=0 search -> R_Bound 14,6,2,0; Found=1, Loc=0. Then an extra Update_R pulse at L=R=0 -> R_Bound stays 0, no wrap.
REQ-032: Update_L and Update_R pulsed together at L=0, R=31 -> bounds unchanged, Proto_Err=1. Proto_Err survives Init_Bound and clears on Resetn=0.
REQ-033: Resetn=0 while L=8, R=14, Found=0 -> next cycle A=0, L=0, R=31, Mem_Addr=15, all flags 0.
REQ-034: Back-to-back searches A_in=20 then A_in=50 with Init_Bound between -> second search ends Found=1, Loc=25, and no stale Loc=10 appears at any point.
